// File: rtl/ysyx_22041071_mem_arb.sv
// rtl/ysyx_22041071_mem_arb.sv - two-master (IF/MEM) arbiter in front of an AXI read-write bridge.
// MEM has fixed priority; one transaction is in flight at a time.
module ysyx_22041071_mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic [1:0]        if_resp,
  output logic              if_done,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mem_resp,
  output logic              mem_done,

  output logic              cpu_ar_valid,
  output logic              cpu_aw_valid,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [LEN_W-1:0]  cpu_len,
  output logic [1:0]        cpu_size,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_ar_ready,
  input  logic              cpu_aw_ready,
  input  logic              cpu_r_valid,
  input  logic [DATA_W-1:0] cpu_r_data,
  input  logic [1:0]        cpu_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t              state;
  logic                owner;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;

  logic grant_mem;
  logic grant_if;
  logic beat;
  logic last_beat;
  logic wr_done;

  // Grants are gated by reset_n so no gnt pulse leaks out while reset is held.
  assign grant_mem = (state == IDLE) && reset_n && mem_req;
  assign grant_if  = (state == IDLE) && reset_n && if_req && !mem_req;
  assign beat      = (state == RD_DATA) && cpu_r_valid;
  assign last_beat = beat && (cnt == len_q);
  assign wr_done   = (state == WR) && cpu_aw_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cnt     <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem) begin
            owner   <= 1'b1;
            addr_q  <= mem_addr;
            len_q   <= mem_len;
            size_q  <= mem_size;
            wdata_q <= mem_wdata;
            cnt     <= '0;
            state   <= mem_we ? WR : RD_REQ;
          end else if (grant_if) begin
            owner   <= 1'b0;
            addr_q  <= if_addr;
            len_q   <= if_len;
            size_q  <= if_size;
            wdata_q <= '0;
            cnt     <= '0;
            state   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (cpu_ar_ready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        WR: begin
          if (wr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_gnt       = grant_if;
  assign mem_gnt      = grant_mem;

  assign cpu_ar_valid = (state == RD_REQ);
  assign cpu_aw_valid = (state == WR);
  assign cpu_addr     = addr_q;
  assign cpu_len      = len_q;
  assign cpu_size     = size_q;
  assign cpu_data     = wdata_q;

  // Read beats route to the owner only; the other side sees zeros.
  assign if_rvalid  = beat && !owner;
  assign if_rdata   = if_rvalid ? cpu_r_data : '0;
  assign if_resp    = if_rvalid ? cpu_resp : 2'b00;
  assign if_done    = last_beat && !owner;

  assign mem_rvalid = beat && owner;
  assign mem_rdata  = mem_rvalid ? cpu_r_data : '0;
  assign mem_resp   = mem_rvalid ? cpu_resp : 2'b00;
  assign mem_done   = (last_beat && owner) || wr_done;

endmodule

// File: tb/tb_ysyx_22041071_mem_arb.sv
// tb/tb_ysyx_22041071_mem_arb.sv - directed self-checking bench for ysyx_22041071_mem_arb.
module tb_ysyx_22041071_mem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic [7:0]  if_len;
  logic [1:0]  if_size;
  logic        if_gnt, if_rvalid, if_done;
  logic [63:0] if_rdata;
  logic [1:0]  if_resp;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_len;
  logic [1:0]  mem_size;
  logic        mem_gnt, mem_rvalid, mem_done;
  logic [63:0] mem_rdata;
  logic [1:0]  mem_resp;
  logic        cpu_ar_valid, cpu_aw_valid;
  logic [63:0] cpu_addr, cpu_data;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size;
  logic        cpu_ar_ready, cpu_aw_ready, cpu_r_valid;
  logic [63:0] cpu_r_data;
  logic [1:0]  cpu_resp;

  int errors = 0;
  int checks = 0;
  int both_valid = 0;

  always #5 clk = ~clk;

  ysyx_22041071_mem_arb #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_resp(if_resp),
    .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .mem_done(mem_done),
    .cpu_ar_valid(cpu_ar_valid), .cpu_aw_valid(cpu_aw_valid), .cpu_addr(cpu_addr),
    .cpu_len(cpu_len), .cpu_size(cpu_size), .cpu_data(cpu_data),
    .cpu_ar_ready(cpu_ar_ready), .cpu_aw_ready(cpu_aw_ready),
    .cpu_r_valid(cpu_r_valid), .cpu_r_data(cpu_r_data), .cpu_resp(cpu_resp)
  );

  always @(negedge clk) if (cpu_ar_valid && cpu_aw_valid) both_valid++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_req = 0; if_addr = 0; if_len = 0; if_size = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_len = 0; mem_size = 0; mem_wdata = 0;
    cpu_ar_ready = 0; cpu_aw_ready = 0; cpu_r_valid = 0; cpu_r_data = 0; cpu_resp = 0;

    // reset state, with a request and a stray beat present
    step; if_req = 1; if_addr = 64'h8000_0000; if_size = 2'b11; cpu_r_valid = 1; settle;
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_ar_valid", 64'(cpu_ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(cpu_aw_valid), 64'd0);
    chk("rst_cpu_addr", cpu_addr, 64'd0);
    chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    if_req = 0; cpu_r_valid = 0;

    // single-beat fetch, ar_ready on second cycle
    step; reset_n = 1'b1; if_req = 1; if_addr = 64'h8000_0000; if_len = 0; if_size = 2'b11; settle;
    chk("f1_if_gnt", 64'(if_gnt), 64'd1);
    chk("f1_ar_before", 64'(cpu_ar_valid), 64'd0);
    step; if_addr = 64'h1234_5678; if_size = 2'b00; settle;
    chk("f1_ar_c1", 64'(cpu_ar_valid), 64'd1);
    chk("f1_gnt_gone", 64'(if_gnt), 64'd0);
    chk("f1_addr", cpu_addr, 64'h8000_0000);
    chk("f1_size", 64'(cpu_size), 64'd3);
    chk("f1_len", 64'(cpu_len), 64'd0);
    step; cpu_ar_ready = 1; settle;
    chk("f1_ar_c2", 64'(cpu_ar_valid), 64'd1);
    step; cpu_ar_ready = 0; cpu_r_valid = 1; cpu_r_data = 64'h13; if_req = 0; settle;
    chk("f1_ar_off", 64'(cpu_ar_valid), 64'd0);
    chk("f1_rvalid", 64'(if_rvalid), 64'd1);
    chk("f1_rdata", if_rdata, 64'h13);
    chk("f1_done", 64'(if_done), 64'd1);
    chk("f1_mem_rvalid", 64'(mem_rvalid), 64'd0);
    step; cpu_r_valid = 0; settle;
    chk("f1_idle_rvalid", 64'(if_rvalid), 64'd0);
    chk("f1_idle_ar", 64'(cpu_ar_valid), 64'd0);

    // simultaneous requests: MEM load first, IF the cycle after mem_done
    step; if_req = 1; if_addr = 64'h8000_0100; if_len = 0; if_size = 2'b10;
    mem_req = 1; mem_we = 0; mem_addr = 64'h8000_1000; mem_len = 0; mem_size = 2'b11; settle;
    chk("arb_mem_gnt", 64'(mem_gnt), 64'd1);
    chk("arb_if_gnt", 64'(if_gnt), 64'd0);
    step; cpu_ar_ready = 1; settle;
    chk("arb_mem_addr", cpu_addr, 64'h8000_1000);
    chk("arb_ar", 64'(cpu_ar_valid), 64'd1);
    step; cpu_ar_ready = 0; cpu_r_valid = 1; cpu_r_data = 64'hAA; mem_req = 0; settle;
    chk("arb_mem_rvalid", 64'(mem_rvalid), 64'd1);
    chk("arb_mem_rdata", mem_rdata, 64'hAA);
    chk("arb_mem_done", 64'(mem_done), 64'd1);
    chk("arb_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("arb_if_gnt_busy", 64'(if_gnt), 64'd0);
    step; cpu_r_valid = 0; settle;
    chk("arb_if_gnt_after", 64'(if_gnt), 64'd1);
    step; cpu_ar_ready = 1; settle;
    chk("arb_if_addr", cpu_addr, 64'h8000_0100);
    step; cpu_ar_ready = 0; cpu_r_valid = 1; cpu_r_data = 64'h55; if_req = 0; settle;
    chk("arb_if_rdata", if_rdata, 64'h55);
    chk("arb_if_done", 64'(if_done), 64'd1);
    step; cpu_r_valid = 0;

    // store with aw_ready on the third cycle
    step; mem_req = 1; mem_we = 1; mem_addr = 64'h8000_2000; mem_wdata = 64'hDEAD_BEEF; mem_len = 0; settle;
    chk("st_gnt", 64'(mem_gnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step;
      if (i == 0) mem_wdata = 64'h0;
      if (i == 2) begin cpu_aw_ready = 1; mem_req = 0; end
      settle;
      chk("st_aw_valid", 64'(cpu_aw_valid), 64'd1);
      chk("st_ar_valid", 64'(cpu_ar_valid), 64'd0);
      chk("st_data", cpu_data, 64'hDEAD_BEEF);
      chk("st_done", 64'(mem_done), (i == 2) ? 64'd1 : 64'd0);
    end
    chk("st_resp", 64'(mem_resp), 64'd0);
    chk("st_addr", cpu_addr, 64'h8000_2000);
    step; cpu_aw_ready = 0; settle;
    chk("st_aw_off", 64'(cpu_aw_valid), 64'd0);

    // 4-beat fetch, gaps between beats, third beat carries resp=10
    step; if_req = 1; if_addr = 64'h8000_0200; if_len = 3; settle;
    chk("b4_gnt", 64'(if_gnt), 64'd1);
    step; cpu_ar_ready = 1; settle;
    chk("b4_len", 64'(cpu_len), 64'd3);
    step; cpu_ar_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step; cpu_r_valid = 1; cpu_r_data = 64'h100 + 64'(i); cpu_resp = (i == 2) ? 2'b10 : 2'b00;
      if (i == 3) if_req = 0;
      settle;
      chk("b4_rvalid", 64'(if_rvalid), 64'd1);
      chk("b4_rdata", if_rdata, 64'h100 + 64'(i));
      chk("b4_resp", 64'(if_resp), (i == 2) ? 64'd2 : 64'd0);
      chk("b4_done", 64'(if_done), (i == 3) ? 64'd1 : 64'd0);
      step; cpu_r_valid = 0; cpu_resp = 0; settle;
      chk("b4_gap_rvalid", 64'(if_rvalid), 64'd0);
      chk("b4_gap_done", 64'(if_done), 64'd0);
    end

    // reset after one of four beats; held request regranted after release
    step; if_req = 1; if_addr = 64'h8000_0300; if_len = 3; settle;
    chk("rs_gnt", 64'(if_gnt), 64'd1);
    step; cpu_ar_ready = 1;
    step; cpu_ar_ready = 0; cpu_r_valid = 1; cpu_r_data = 64'h77; settle;
    chk("rs_beat0", 64'(if_rvalid), 64'd1);
    step; settle;
    reset_n = 0; settle;
    chk("rs_rvalid", 64'(if_rvalid), 64'd0);
    chk("rs_done", 64'(if_done), 64'd0);
    chk("rs_gnt_held", 64'(if_gnt), 64'd0);
    chk("rs_addr", cpu_addr, 64'd0);
    chk("rs_len", 64'(cpu_len), 64'd0);
    chk("rs_ar", 64'(cpu_ar_valid), 64'd0);
    step; cpu_r_valid = 0; reset_n = 1; settle;
    chk("rs_regrant", 64'(if_gnt), 64'd1);
    step; cpu_ar_ready = 1; settle;
    chk("rs_ar2", 64'(cpu_ar_valid), 64'd1);
    chk("rs_addr2", cpu_addr, 64'h8000_0300);
    step; cpu_ar_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_r_valid = 1; cpu_r_data = 64'(i);
      if (i == 3) if_req = 0;
      settle;
      chk("rs_done2", 64'(if_done), (i == 3) ? 64'd1 : 64'd0);
      step;
    end
    cpu_r_valid = 0;

    // stray beats while idle are dropped
    for (int i = 0; i < 2; i++) begin
      step; cpu_r_valid = 1; cpu_r_data = 64'hBAD; settle;
      chk("idle_if_rvalid", 64'(if_rvalid), 64'd0);
      chk("idle_mem_rvalid", 64'(mem_rvalid), 64'd0);
      chk("idle_if_done", 64'(if_done), 64'd0);
    end
    step; cpu_r_valid = 0; settle;
    chk("idle_ar", 64'(cpu_ar_valid), 64'd0);

    // 256-beat MEM load; no wrap before done
    step; mem_req = 1; mem_we = 0; mem_addr = 64'h8000_4000; mem_len = 8'd255; settle;
    chk("l256_gnt", 64'(mem_gnt), 64'd1);
    step; cpu_ar_ready = 1; settle;
    chk("l256_idle_check", 64'(cpu_ar_valid), 64'd1);
    step; cpu_ar_ready = 0;
    for (int i = 0; i < 256; i++) begin
      cpu_r_valid = 1; cpu_r_data = 64'(i);
      if (i == 255) mem_req = 0;
      settle;
      if (i == 254 || i == 255 || i == 0) chk("l256_done", 64'(mem_done), (i == 255) ? 64'd1 : 64'd0);
      if (mem_done && i != 255) chk("l256_early_done", 64'(i), 64'd255);
      step;
    end
    cpu_r_valid = 0; settle;
    chk("l256_after", 64'(mem_rvalid), 64'd0);
    chk("never_both_valid", 64'(both_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
